// File: rtl/hdb3_link_ctrl_pkg.sv
// Shared definitions for the HDB3 line-side link controller: link states,
// symbol encodings common with the decoder, and default parameters.
package hdb3_link_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOS  = 2'b00,
        ST_ACQ  = 2'b01,
        ST_LOCK = 2'b10
    } link_state_e;

    // Encoded as {n, p} so it matches the decoder's view of the line pair.
    typedef enum logic [1:0] {
        SYM_ZERO = 2'b00,
        SYM_POS  = 2'b01,
        SYM_NEG  = 2'b10,
        SYM_ILL  = 2'b11
    } sym_e;

    localparam int LOS_N_DEF   = 32;
    localparam int ACQ_N_DEF   = 64;
    localparam int WIN_LEN_DEF = 256;
    localparam int ERR_TH_DEF  = 4;
    localparam int DEC_LAT_DEF = 5;
    localparam int CNT_W_DEF   = 16;

    function automatic sym_e classify_sym(input logic p, input logic n);
        sym_e s;
        case ({n, p})
            2'b00:   s = SYM_ZERO;
            2'b01:   s = SYM_POS;
            2'b10:   s = SYM_NEG;
            2'b11:   s = SYM_ILL;
            default: s = SYM_ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hdb3_link_ctrl_cv_det.sv
// Code-violation detector: classifies each line symbol, tracks pulse and
// V polarity plus the zero-run length, and reports CVs and loss of signal.
module hdb3_cv_det
    import hdb3_link_ctrl_pkg::*;
#(
    parameter int LOS_N = LOS_N_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hdb3_p,
    input  logic hdb3_n,
    output logic cv,
    output logic illegal,
    output logic pulse,
    output logic zrun_los
);

    localparam int            ZW        = $clog2(LOS_N + 1);
    localparam logic [ZW-1:0] ZRUN_MAX  = ZW'(LOS_N);
    localparam logic [ZW-1:0] ZRUN_ONE  = ZW'(1);
    localparam logic [ZW-1:0] ZRUN_PREV = ZW'(3);
    localparam logic          RUN_CV_EN = (LOS_N > 4);

    sym_e          sym_s;
    logic          pulse_s;
    logic          pol_s;
    logic          ill_s;
    logic          is_v_s;
    logic          cv_v_s;
    logic          cv_z_s;
    logic [ZW-1:0] zrun_next_s;

    logic          last_pol_r;
    logic          last_vpol_r;
    logic          pol_known_r;
    logic          v_known_r;
    logic [ZW-1:0] zrun_r;

    // Symbol classification, V detection and CV source evaluation.
    always_comb begin
        sym_s       = classify_sym(hdb3_p, hdb3_n);
        pulse_s     = 1'b0;
        pol_s       = 1'b0;
        ill_s       = 1'b0;
        zrun_next_s = zrun_r;
        case (sym_s)
            SYM_POS: begin
                pulse_s     = 1'b1;
                pol_s       = 1'b1;
                zrun_next_s = '0;
            end
            SYM_NEG: begin
                pulse_s     = 1'b1;
                zrun_next_s = '0;
            end
            SYM_ZERO: begin
                if (zrun_r != ZRUN_MAX) begin
                    zrun_next_s = zrun_r + ZRUN_ONE;
                end else begin
                    zrun_next_s = zrun_r;
                end
            end
            SYM_ILL: begin
                // Illegal symbols neither extend nor break the zero run.
                ill_s       = 1'b1;
                zrun_next_s = zrun_r;
            end
            default: begin
                zrun_next_s = zrun_r;
            end
        endcase
        is_v_s   = pulse_s && pol_known_r && (pol_s == last_pol_r) && !clr;
        cv_v_s   = is_v_s && v_known_r && (pol_s == last_vpol_r);
        cv_z_s   = (sym_s == SYM_ZERO) && (zrun_r == ZRUN_PREV) && RUN_CV_EN;
        cv       = !clr && (ill_s || cv_v_s || cv_z_s);
        illegal  = ill_s;
        pulse    = pulse_s;
        zrun_los = (zrun_next_s == ZRUN_MAX);
    end

    // Polarity history and zero-run register; the first pulse seen during
    // clear still seeds last_pol so tracking is valid on leaving LOS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pol_r  <= 1'b0;
            last_vpol_r <= 1'b0;
            pol_known_r <= 1'b0;
            v_known_r   <= 1'b0;
            zrun_r      <= '0;
        end else begin
            zrun_r <= zrun_next_s;
            if (pulse_s) begin
                last_pol_r  <= pol_s;
                pol_known_r <= 1'b1;
            end else if (clr) begin
                pol_known_r <= 1'b0;
            end
            if (clr) begin
                v_known_r <= 1'b0;
            end else if (is_v_s) begin
                last_vpol_r <= pol_s;
                v_known_r   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdb3_link_ctrl.sv
// HDB3 link controller: LOS/ACQ/LOCK state machine, decoder clear, latency-
// aligned data_valid and an optional CV counter (macro HDB3_LINK_CV_CNT_EN).
module hdb3_link_ctrl
    import hdb3_link_ctrl_pkg::*;
#(
    parameter int LOS_N   = LOS_N_DEF,
    parameter int ACQ_N   = ACQ_N_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int ERR_TH  = ERR_TH_DEF,
    parameter int DEC_LAT = DEC_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hdb3_p,
    input  logic             hdb3_n,
    input  logic             cnt_clr,
    output logic             dec_clr_n,
    output logic             data_valid,
    output logic [1:0]       link_state,
    output logic             los,
    output logic             cv_pulse,
    output logic             illegal,
    output logic [CNT_W-1:0] cv_cnt
);

    localparam int            AW       = $clog2(ACQ_N + 1);
    localparam int            WW       = $clog2(WIN_LEN);
    localparam int            EW       = $clog2(ERR_TH + 1);
    localparam logic [AW-1:0] ACQ_MAX  = AW'(ACQ_N);
    localparam logic [AW-1:0] ACQ_ONE  = AW'(1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);
    localparam logic [WW-1:0] WIN_ONE  = WW'(1);
    localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_TH);
    localparam logic [EW-1:0] ERR_ONE  = EW'(1);

    link_state_e          state_r;
    link_state_e          state_next_s;
    link_state_e          fsm_next_s;
    logic [AW-1:0]        acq_cnt_r;
    logic [AW-1:0]        acq_next_s;
    logic [WW-1:0]        win_cnt_r;
    logic [WW-1:0]        win_next_s;
    logic [EW-1:0]        err_cnt_r;
    logic [EW-1:0]        err_next_s;
    logic [EW-1:0]        err_base_s;
    logic                 cv_s;
    logic                 ill_s;
    logic                 pulse_s;
    logic                 zrun_los_s;
    logic                 dec_clr_n_r;
    logic                 los_r;
    logic                 cv_pulse_r;
    logic                 illegal_r;
    logic [DEC_LAT-1:0]   dv_sr_r;

    hdb3_cv_det #(
        .LOS_N (LOS_N)
    ) u_cv_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_r == ST_LOS),
        .hdb3_p   (hdb3_p),
        .hdb3_n   (hdb3_n),
        .cv       (cv_s),
        .illegal  (ill_s),
        .pulse    (pulse_s),
        .zrun_los (zrun_los_s)
    );

    // Next-state and window counter logic; counters idle at zero outside
    // their own state so each entry starts from a clean count.
    always_comb begin
        fsm_next_s = state_r;
        acq_next_s = '0;
        win_next_s = '0;
        err_next_s = '0;
        if (win_cnt_r == WIN_LAST) begin
            err_base_s = '0;
        end else begin
            err_base_s = err_cnt_r;
        end
        case (state_r)
            ST_LOS: begin
                if (pulse_s) begin
                    fsm_next_s = ST_ACQ;
                end else begin
                    fsm_next_s = ST_LOS;
                end
            end
            ST_ACQ: begin
                if (cv_s) begin
                    acq_next_s = '0;
                end else begin
                    acq_next_s = acq_cnt_r + ACQ_ONE;
                end
                if (!cv_s && (acq_next_s == ACQ_MAX)) begin
                    fsm_next_s = ST_LOCK;
                end else begin
                    fsm_next_s = ST_ACQ;
                end
            end
            ST_LOCK: begin
                // A CV on the last window symbol is charged to the new window.
                if (win_cnt_r == WIN_LAST) begin
                    win_next_s = '0;
                end else begin
                    win_next_s = win_cnt_r + WIN_ONE;
                end
                if (cv_s) begin
                    err_next_s = err_base_s + ERR_ONE;
                end else begin
                    err_next_s = err_base_s;
                end
                if (cv_s && (err_next_s == ERR_MAX)) begin
                    fsm_next_s = ST_ACQ;
                end else begin
                    fsm_next_s = ST_LOCK;
                end
            end
            default: begin
                fsm_next_s = ST_LOS;
            end
        endcase
        if (zrun_los_s) begin
            state_next_s = ST_LOS;
        end else begin
            state_next_s = fsm_next_s;
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_LOS;
            acq_cnt_r   <= '0;
            win_cnt_r   <= '0;
            err_cnt_r   <= '0;
            dec_clr_n_r <= 1'b0;
            los_r       <= 1'b1;
            cv_pulse_r  <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            acq_cnt_r   <= acq_next_s;
            win_cnt_r   <= win_next_s;
            err_cnt_r   <= err_next_s;
            dec_clr_n_r <= (state_next_s != ST_LOS);
            los_r       <= (state_next_s == ST_LOS);
            cv_pulse_r  <= cv_s;
            illegal_r   <= ill_s;
        end
    end

    // Delay the LOCK indication to line up with the decoder's data_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_sr_r <= '0;
        end else begin
            dv_sr_r <= {dv_sr_r[DEC_LAT-2:0], (state_r == ST_LOCK)};
        end
    end

`ifdef HDB3_LINK_CV_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cv_cnt_r;

    // Saturating CV counter; a clear beats a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_cnt_r <= '0;
        end else if (cnt_clr) begin
            cv_cnt_r <= '0;
        end else if (cv_pulse_r && (cv_cnt_r != CNT_MAX)) begin
            cv_cnt_r <= cv_cnt_r + CNT_ONE;
        end
    end

    assign cv_cnt = cv_cnt_r;
`else
    logic unused_cnt_clr_s;

    assign unused_cnt_clr_s = cnt_clr;
    assign cv_cnt           = '0;
`endif

    assign link_state = state_r;
    assign los        = los_r;
    assign dec_clr_n  = dec_clr_n_r;
    assign cv_pulse   = cv_pulse_r;
    assign illegal    = illegal_r;
    assign data_valid = dv_sr_r[DEC_LAT-1];

endmodule

// File: tb/tb_hdb3_link_ctrl.sv
// Directed bench for hdb3_link_ctrl: LOS idle, acquisition, CV handling,
// illegal symbols, LOS re-entry, counter clear/saturation and async reset.
module tb_hdb3_link_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hdb3_p;
    logic        hdb3_n;
    logic        cnt_clr;
    logic        dec_clr_n;
    logic        data_valid;
    logic [1:0]  link_state;
    logic        los;
    logic        cv_pulse;
    logic        illegal;
    logic [15:0] cv_cnt;

    int   checks  = 0;
    int   errors  = 0;
    int   cv_seen = 0;
    logic bpol;
    logic bvpol;

`ifdef HDB3_LINK_CV_CNT_EN
    localparam int SAT_N = 65540;
`else
    localparam int SAT_N = 300;
`endif

    hdb3_link_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hdb3_p     (hdb3_p),
        .hdb3_n     (hdb3_n),
        .cnt_clr    (cnt_clr),
        .dec_clr_n  (dec_clr_n),
        .data_valid (data_valid),
        .link_state (link_state),
        .los        (los),
        .cv_pulse   (cv_pulse),
        .illegal    (illegal),
        .cv_cnt     (cv_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && cv_pulse) cv_seen++;
    end

    function automatic logic [15:0] exp_cnt(input logic [15:0] v);
`ifdef HDB3_LINK_CV_CNT_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic send(input logic p, input logic n);
        hdb3_p = p;
        hdb3_n = n;
        @(posedge clk);
        #1;
    endtask

    task automatic zero();
        send(1'b0, 1'b0);
    endtask

    task automatic mark();
        bpol = ~bpol;
        send(bpol, ~bpol);
    endtask

    task automatic vsym();
        send(bpol, ~bpol);
        bvpol = bpol;
    endtask

    // Legal 4-zero substitution: 000V or B00V so V alternates in polarity.
    task automatic sub4();
        if (bpol != bvpol) begin
            zero(); zero(); zero(); vsym();
        end else begin
            bpol = ~bpol;
            send(bpol, ~bpol);
            zero(); zero(); vsym();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hdb3_p = 1'b0; hdb3_n = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (link_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want %b", link_state, 2'b00); end
        checks++; if (los !== 1'b1) begin errors++; $display("FAIL reset_los: got %b want %b", los, 1'b1); end
        checks++; if (dec_clr_n !== 1'b0) begin errors++; $display("FAIL reset_dec_clr_n: got %b want %b", dec_clr_n, 1'b0); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b want %b", data_valid, 1'b0); end
        checks++; if (cv_pulse !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b want 00", cv_pulse, illegal); end
        checks++; if (cv_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cv_cnt: got %h want %h", cv_cnt, 16'h0000); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_los_idle();
        int c0;
        c0 = cv_seen;
        repeat (100) zero();
        checks++; if (link_state !== 2'b00) begin errors++; $display("FAIL idle_state: got %b want %b", link_state, 2'b00); end
        checks++; if (los !== 1'b1) begin errors++; $display("FAIL idle_los: got %b want %b", los, 1'b1); end
        checks++; if (dec_clr_n !== 1'b0) begin errors++; $display("FAIL idle_dec_clr_n: got %b want %b", dec_clr_n, 1'b0); end
        checks++; if (cv_seen !== c0) begin errors++; $display("FAIL idle_no_cv: got %0d cv pulses want 0", cv_seen - c0); end
    endtask

    task automatic test_acquire();
        int c0;
        c0 = cv_seen; bpol = 1'b0; bvpol = 1'b1;
        mark();
        checks++; if (link_state !== 2'b01) begin errors++; $display("FAIL acq_entry: got %b want %b", link_state, 2'b01); end
        checks++; if (dec_clr_n !== 1'b1 || los !== 1'b0) begin errors++; $display("FAIL acq_release: got dec_clr_n=%b los=%b want 1 0", dec_clr_n, los); end
        for (int i = 0; i < 8; i++) begin mark(); mark(); sub4(); end
        for (int i = 0; i < 3; i++) begin mark(); sub4(); end
        checks++; if (link_state !== 2'b01) begin errors++; $display("FAIL acq_63: got %b want %b", link_state, 2'b01); end
        mark();
        checks++; if (link_state !== 2'b10) begin errors++; $display("FAIL acq_lock: got %b want %b", link_state, 2'b10); end
        repeat (4) mark();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL dv_early: got %b want %b", data_valid, 1'b0); end
        mark();
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL dv_rise: got %b want %b", data_valid, 1'b1); end
        checks++; if (cv_seen !== c0) begin errors++; $display("FAIL acq_no_cv: got %0d cv pulses want 0", cv_seen - c0); end
        checks++; if (cv_cnt !== 16'h0000) begin errors++; $display("FAIL acq_cv_cnt: got %h want %h", cv_cnt, 16'h0000); end
    endtask

    task automatic test_zero_run_cv();
        logic [1:0] exp_st;
        for (int r = 0; r < 4; r++) begin
            mark();
            zero(); zero(); zero();
            checks++; if (cv_pulse !== 1'b0) begin errors++; $display("FAIL zrun3_cv[%0d]: got %b want %b", r, cv_pulse, 1'b0); end
            zero();
            checks++; if (cv_pulse !== 1'b1) begin errors++; $display("FAIL zrun4_cv[%0d]: got %b want %b", r, cv_pulse, 1'b1); end
            exp_st = (r < 3) ? 2'b10 : 2'b01;
            checks++; if (link_state !== exp_st) begin errors++; $display("FAIL zrun_state[%0d]: got %b want %b", r, link_state, exp_st); end
            mark();
            checks++; if (cv_cnt !== exp_cnt(16'(r + 1))) begin errors++; $display("FAIL zrun_cnt[%0d]: got %h want %h", r, cv_cnt, exp_cnt(16'(r + 1))); end
        end
        repeat (3) mark();
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL dv_hold: got %b want %b", data_valid, 1'b1); end
        mark();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL dv_fall: got %b want %b", data_valid, 1'b0); end
    endtask

    task automatic test_double_v();
        int c0;
        for (int i = 0; i < 20 && link_state != 2'b10; i++) begin mark(); sub4(); end
        checks++; if (link_state !== 2'b10) begin errors++; $display("FAIL relock: got %b want %b", link_state, 2'b10); end
        for (int i = 0; i < 4 && bvpol != 1'b1; i++) begin mark(); sub4(); end
        if (bpol != 1'b1) mark();
        c0 = cv_seen;
        vsym();
        checks++; if (cv_pulse !== 1'b1) begin errors++; $display("FAIL dbl_v_cv: got %b want %b", cv_pulse, 1'b1); end
        mark();
        checks++; if (cv_pulse !== 1'b0) begin errors++; $display("FAIL dbl_v_single: got %b want %b", cv_pulse, 1'b0); end
        vsym();
        checks++; if (cv_pulse !== 1'b0) begin errors++; $display("FAIL vpol_kept: got %b want %b", cv_pulse, 1'b0); end
        checks++; if (cv_seen - c0 !== 1) begin errors++; $display("FAIL dbl_v_count: got %0d want 1", cv_seen - c0); end
        checks++; if (cv_cnt !== exp_cnt(16'd5)) begin errors++; $display("FAIL dbl_v_cnt: got %h want %h", cv_cnt, exp_cnt(16'd5)); end
        checks++; if (link_state !== 2'b10) begin errors++; $display("FAIL dbl_v_state: got %b want %b", link_state, 2'b10); end
    endtask

    task automatic test_illegal_los();
        send(1'b1, 1'b1);
        checks++; if (illegal !== 1'b1 || cv_pulse !== 1'b1) begin errors++; $display("FAIL ill_strobe: got ill=%b cv=%b want 1 1", illegal, cv_pulse); end
        zero();
        checks++; if (illegal !== 1'b0 || cv_pulse !== 1'b0) begin errors++; $display("FAIL ill_one_cycle: got ill=%b cv=%b want 0 0", illegal, cv_pulse); end
        zero(); zero(); zero();
        checks++; if (cv_pulse !== 1'b1) begin errors++; $display("FAIL ill_zrun4: got %b want %b", cv_pulse, 1'b1); end
        repeat (27) zero();
        checks++; if (link_state !== 2'b10) begin errors++; $display("FAIL los_31: got %b want %b", link_state, 2'b10); end
        zero();
        checks++; if (link_state !== 2'b00 || los !== 1'b1) begin errors++; $display("FAIL los_32: got state=%b los=%b want 00 1", link_state, los); end
        checks++; if (dec_clr_n !== 1'b0) begin errors++; $display("FAIL los_dec_clr: got %b want %b", dec_clr_n, 1'b0); end
        checks++; if (cv_cnt !== exp_cnt(16'd7)) begin errors++; $display("FAIL los_cnt: got %h want %h", cv_cnt, exp_cnt(16'd7)); end
    endtask

    task automatic test_cnt_clr_sat();
        cnt_clr = 1'b1; zero(); cnt_clr = 1'b0;
        checks++; if (cv_cnt !== 16'h0000) begin errors++; $display("FAIL clr_idle: got %h want %h", cv_cnt, 16'h0000); end
        mark();
        repeat (4) send(1'b1, 1'b1);
        checks++; if (cv_pulse !== 1'b1) begin errors++; $display("FAIL clr_pulse: got %b want %b", cv_pulse, 1'b1); end
        checks++; if (cv_cnt !== exp_cnt(16'd3)) begin errors++; $display("FAIL cnt_three: got %h want %h", cv_cnt, exp_cnt(16'd3)); end
        cnt_clr = 1'b1; send(1'b1, 1'b1); cnt_clr = 1'b0;
        checks++; if (cv_cnt !== 16'h0000) begin errors++; $display("FAIL clr_priority: got %h want %h", cv_cnt, 16'h0000); end
        send(1'b1, 1'b1);
        checks++; if (cv_cnt !== exp_cnt(16'd1)) begin errors++; $display("FAIL clr_resume: got %h want %h", cv_cnt, exp_cnt(16'd1)); end
        repeat (SAT_N) send(1'b1, 1'b1);
        checks++; if (cv_cnt !== exp_cnt(16'hFFFF)) begin errors++; $display("FAIL cnt_sat: got %h want %h", cv_cnt, exp_cnt(16'hFFFF)); end
        send(1'b1, 1'b1);
        checks++; if (cv_cnt !== exp_cnt(16'hFFFF)) begin errors++; $display("FAIL cnt_sat_hold: got %h want %h", cv_cnt, exp_cnt(16'hFFFF)); end
    endtask

    task automatic test_reset_mid();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (link_state !== 2'b00 || los !== 1'b1) begin errors++; $display("FAIL mid_state: got state=%b los=%b want 00 1", link_state, los); end
        checks++; if (dec_clr_n !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL mid_dec: got dec_clr_n=%b dv=%b want 0 0", dec_clr_n, data_valid); end
        checks++; if (cv_pulse !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL mid_strobes: got cv=%b ill=%b want 0 0", cv_pulse, illegal); end
        checks++; if (cv_cnt !== 16'h0000) begin errors++; $display("FAIL mid_cnt: got %h want %h", cv_cnt, 16'h0000); end
        hdb3_p = 1'b0; hdb3_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_los_idle();
        test_acquire();
        test_zero_run_cv();
        test_double_v();
        test_illegal_los();
        test_cnt_clr_sat();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
